// File: rtl/add_seq_if.sv
// Request/result bundle for add_seq. The ovf signal exists only when
// ADD_SEQ_OVF_EN is defined.
interface add_seq_if #(
   parameter int WIDTH = 16
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             busy;
`ifdef ADD_SEQ_OVF_EN
   logic             ovf;
`endif

   // Both ports are valid/ready: a transfer happens on a rising edge where
   // valid and ready are both high; valid does not wait for ready.
   modport master (
      output start_valid, a, b, ci, res_ready,
      input  start_ready, res_valid, sum, co, busy
`ifdef ADD_SEQ_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start_valid, a, b, ci, res_ready,
      output start_ready, res_valid, sum, co, busy
`ifdef ADD_SEQ_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/add_seq.sv
// WIDTH-bit adder that reuses one 4-bit slice, one nibble per clock, LSB first.
// Define ADD_SEQ_OVF_EN to add the signed-overflow output.
module add_seq #(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   add_seq_if.slave   bus,
   output logic [1:0] dbg_state_o
);
   localparam int N  = WIDTH / 4;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ADD_SEQ_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [3:0] nib_a;
   logic [3:0] nib_b;
   logic [4:0] slice;
   logic       last;

   // The shared slice: operand nibbles selected by the counter.
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int i = 0; i < N; i++) begin
         if (cnt_q == CW'(i)) begin
            nib_a = a_q[4*i +: 4];
            nib_b = b_q[4*i +: 4];
         end
      end
      slice = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
      last  = (cnt_q == CW'(N - 1));
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      co_d    = co_q;
      cnt_d   = cnt_q;
`ifdef ADD_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.ci;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            for (int i = 0; i < N; i++) begin
               if (cnt_q == CW'(i)) sum_d[4*i +: 4] = slice[3:0];
            end
            carry_d = slice[4];
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
               co_d    = slice[4];
`ifdef ADD_SEQ_OVF_EN
               // On the last edge the slice output is the top nibble of the sum.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice[3] != a_q[WIDTH-1]);
`endif
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
         cnt_q   <= '0;
`ifdef ADD_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         co_q    <= co_d;
         cnt_q   <= cnt_d;
`ifdef ADD_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign bus.start_ready = (state_q == S_IDLE);
   assign bus.res_valid   = (state_q == S_DONE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.sum         = sum_q;
   assign bus.co          = co_q;
`ifdef ADD_SEQ_OVF_EN
   assign bus.ovf         = ovf_q;
`endif
   assign dbg_state_o     = state_q;
endmodule

// File: doc/add_seq.md
# add_seq

Multi-cycle sequencer that performs WIDTH-bit addition by time-multiplexing a single internal 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first. It latches operands through a valid/ready request port, chains the carry through a register between nibbles, and returns the sum through a valid/ready result port. It sits between a requester (test harness or control logic) and the shared 4-bit adder datapath, trading latency for area on wide adds.

## Interface
- WIDTH, 16: operand/sum width in bits; must be a multiple of 4, minimum 4. N = WIDTH/4 nibbles.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  requester presents operands.
- start_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A, sampled on the start handshake.
- b  input  WIDTH  operand B, sampled on the start handshake.
- ci  input  1  carry-in to nibble 0, sampled on the start handshake.
- res_valid  output  1  sum/co valid (high only in DONE).
- res_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered sum.
- co  output  1  registered carry-out of the top nibble.
- busy  output  1  high in RUN or DONE.
- ovf  output  1  signed overflow; present only with ADD_SEQ_OVF_EN.

## Operation
- Reset: state=IDLE, start_ready=1, res_valid=0, busy=0, sum=0, co=0, ovf=0, carry reg=0, nibble counter=0, operand regs=0.
- IDLE: start_ready=1. On start_valid&start_ready at an edge: latch a, b; carry reg<=ci; counter<=0; sum<=0; go RUN.
- RUN: each edge, slice computes a_r[4i+3:4i] + b_r[4i+3:4i] + carry reg for i=counter; sum[4i+3:4i]<=slice S; carry reg<=slice Co; counter<=counter+1. On the edge where counter==N-1: co<=slice Co, go DONE.
- DONE: res_valid=1; sum, co, ovf held stable. On res_valid&res_ready at an edge: go IDLE. sum/co/ovf retain values in IDLE until the next accept clears sum.
- start_valid outside IDLE is ignored (no latch, no queue). Operand inputs may change freely after the accept edge.
- Arithmetic: {co,sum} = a + b + ci, exact, unsigned, modulo 2^(WIDTH+1).
- WIDTH=4: RUN lasts exactly one cycle.
- rst_n assertion in any state (including mid-RUN) aborts immediately to reset values; partial sum is discarded, no res_valid pulse.

## Timing
- Accept edge E0 -> RUN on edges E1..EN -> res_valid high after EN (latency N cycles from accept).
- res_ready may be high before res_valid; result retires on the first edge in DONE with res_ready=1 (edge EN+1 at earliest).
- Minimum issue period N+2 cycles (accept, N RUN, retire); next accept at EN+2 earliest.
- res_ready low holds DONE indefinitely; no output changes while held.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Configuration
- ADD_SEQ_OVF_EN defined: ovf port exists; on the final RUN edge ovf<=(a_r[MSB]==b_r[MSB]) && (final sum MSB != a_r[MSB]); reset 0; held in DONE/IDLE like sum.
- ADD_SEQ_OVF_EN undefined: ovf port and its logic absent; all other behaviour identical.

## Test plan
- WIDTH=16, a=0x1234, b=0x0FFF, ci=0 -> sum=0x2233, co=0, ovf=0; res_valid rises exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, co=1, ovf=0 (carry ripples through all 4 nibbles); a=0xFFFF, b=0xFFFF, ci=1 -> sum=0xFFFF, co=1.
- a=0x7FFF, b=0x0001, ci=0 -> sum=0x8000, co=0, ovf=1 (macro on); a=0x8000, b=0x8000 -> sum=0x0000, co=1, ovf=1.
- Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid, sum, co stable; start_valid pulsed with new operands during RUN and DONE -> ignored, start_ready=0; retire then new op starts at EN+2.
- Reset mid-RUN: rst_n low after E2 -> outputs immediately at reset values, state IDLE; next op 0x0001+0x0001 -> 0x0002, unaffected.
- WIDTH=4: a=0xF, b=0x1, ci=0 -> sum=0x0, co=1, res_valid 1 cycle after accept; back-to-back ops with res_ready=1 issue every 3 cycles.
